// File: rtl/hex_byte_sequencer_pkg.sv
// Shared state encoding and constants for the hex byte sequencer.
// Pure definitions: no logic, no latency, no flow control.
package hexseq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [3:0] HEXSEQ_BLANK_NIBBLE = 4'h0;

endpackage

// File: rtl/hex_byte_sequencer_dwell_timer.sv
// Phase dwell counter: expire is combinational on the last cycle of a phase while run is high.
// No backpressure; clear always wins and restarts the count from zero.
module dwell_timer #(
  parameter int DWELL_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] cnt;

  // With a dwell of one the counter never leaves zero, so the compare is always true.
  assign expire = run && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hex_byte_sequencer.sv
// Shows a byte on one seven-segment digit as high nibble, low nibble (dp lit), blank gap; outputs follow load by one edge.
// load is never refused and restarts the sequence; HEXSEQ_REPEAT_EN makes the byte loop until the next load or reset.
module hex_byte_sequencer
  import hexseq_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       dp,
  output logic       busy,
  output logic       done
);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] held;
  logic       expire;

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (load),
    .run   (state != IDLE),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      held  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (load) begin
        held <= data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    nibble    = HEXSEQ_BLANK_NIBBLE;
    blank     = 1'b1;
    dp        = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);

    case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      HIGH: begin
        nibble = held[7:4];
        blank  = 1'b0;
        if (expire) begin
          state_nxt = LOW;
        end
      end
      LOW: begin
        nibble = held[3:0];
        blank  = 1'b0;
        dp     = 1'b1;
        if (expire) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        nibble = held[3:0];
        done   = expire && !load;
        if (expire) begin
`ifdef HEXSEQ_REPEAT_EN
          state_nxt = HIGH;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A fresh byte always takes priority over finishing the current one.
    if (load) begin
      state_nxt = HIGH;
    end
  end

endmodule

// File: tb/tb_hex_byte_sequencer.sv
// Directed table-driven bench for hex_byte_sequencer at dwell 4, 1 and 2.
// Honours HEXSEQ_REPEAT_EN in its expectations when the build defines it.
module tb_hex_byte_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       ld4 = 1'b0, ld1 = 1'b0, ld2 = 1'b0;
  logic [7:0] dat4 = 8'h00, dat1 = 8'h00, dat2 = 8'h00;
  logic [3:0] nib4, nib1, nib2;
  logic       blk4, blk1, blk2, dp4, dp1, dp2;
  logic       bsy4, bsy1, bsy2, dn4, dn1, dn2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  hex_byte_sequencer #(.DWELL_CYCLES(4)) u4 (
    .clk(clk), .reset(reset), .load(ld4), .data(dat4),
    .nibble(nib4), .blank(blk4), .dp(dp4), .busy(bsy4), .done(dn4)
  );
  hex_byte_sequencer #(.DWELL_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .load(ld1), .data(dat1),
    .nibble(nib1), .blank(blk1), .dp(dp1), .busy(bsy1), .done(dn1)
  );
  hex_byte_sequencer #(.DWELL_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .load(ld2), .data(dat2),
    .nibble(nib2), .blank(blk2), .dp(dp2), .busy(bsy2), .done(dn2)
  );

  // Output bundle layout: {nibble, blank, dp, busy, done}
  function automatic logic [7:0] pk(input logic [3:0] n, input logic b, input logic d,
                                    input logic bz, input logic dn);
    return {n, b, d, bz, dn};
  endfunction

  wire [7:0] out4 = {nib4, blk4, dp4, bsy4, dn4};
  wire [7:0] out1 = {nib1, blk1, dp1, bsy1, dn1};
  wire [7:0] out2 = {nib2, blk2, dp2, bsy2, dn2};

  localparam logic [7:0] IDLE_OUT = 8'b0000_1000;

  typedef struct {
    logic       ld;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[34];

  function automatic vec_t mk(input logic l, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.ld  = l;
    v.dat = d;
    v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got {nib,blank,dp,busy,done}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic cyc1(input logic l, input logic [7:0] d, input logic [7:0] e, input string n);
    @(negedge clk);
    ld1  = l;
    dat1 = d;
    #1;
    chk(n, out1, e);
  endtask

  initial begin
    // Sequence A7, then 3C pre-empted by 51 during the second LOW cycle.
    tbl[0] = mk(1'b1, 8'hA7, IDLE_OUT);
    for (int k = 1; k <= 4; k++)  tbl[k] = mk(1'b0, 8'h00, pk(4'hA, 0, 0, 1, 0));
    for (int k = 5; k <= 8; k++)  tbl[k] = mk(1'b0, 8'h00, pk(4'h7, 0, 1, 1, 0));
    for (int k = 9; k <= 12; k++) tbl[k] = mk(1'b0, 8'h00, pk(4'h7, 1, 0, 1, k == 12));
`ifdef HEXSEQ_REPEAT_EN
    tbl[13] = mk(1'b0, 8'h00, pk(4'hA, 0, 0, 1, 0));
    tbl[14] = mk(1'b1, 8'h3C, pk(4'hA, 0, 0, 1, 0));
`else
    tbl[13] = mk(1'b0, 8'h00, IDLE_OUT);
    tbl[14] = mk(1'b1, 8'h3C, IDLE_OUT);
`endif
    for (int k = 15; k <= 18; k++) tbl[k] = mk(1'b0, 8'h00, pk(4'h3, 0, 0, 1, 0));
    tbl[19] = mk(1'b0, 8'h00, pk(4'hC, 0, 1, 1, 0));
    tbl[20] = mk(1'b1, 8'h51, pk(4'hC, 0, 1, 1, 0));
    for (int k = 21; k <= 24; k++) tbl[k] = mk(1'b0, 8'h00, pk(4'h5, 0, 0, 1, 0));
    for (int k = 25; k <= 28; k++) tbl[k] = mk(1'b0, 8'h00, pk(4'h1, 0, 1, 1, 0));
    for (int k = 29; k <= 32; k++) tbl[k] = mk(1'b0, 8'h00, pk(4'h1, 1, 0, 1, k == 32));
`ifdef HEXSEQ_REPEAT_EN
    tbl[33] = mk(1'b0, 8'h00, pk(4'h5, 0, 0, 1, 0));
`else
    tbl[33] = mk(1'b0, 8'h00, IDLE_OUT);
`endif

    // Reset values, then ten idle cycles.
    #2;
    chk("reset_u4", out4, IDLE_OUT);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle4[%0d]", k), out4, IDLE_OUT);
      chk($sformatf("idle1[%0d]", k), out1, IDLE_OUT);
    end

    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      ld4  = tbl[i].ld;
      dat4 = tbl[i].dat;
      #1;
      chk($sformatf("seq4[%0d]", i), out4, tbl[i].exp);
    end
    @(negedge clk);
    ld4 = 1'b0;

    // Dwell of one: single-cycle phases, then a load colliding with the GAP cycle.
    cyc1(1'b1, 8'hFF, IDLE_OUT,                "d1_load");
    cyc1(1'b0, 8'h00, pk(4'hF, 0, 0, 1, 0),    "d1_high");
    cyc1(1'b0, 8'h00, pk(4'hF, 0, 1, 1, 0),    "d1_low");
    cyc1(1'b0, 8'h00, pk(4'hF, 1, 0, 1, 1),    "d1_gap_done");
`ifdef HEXSEQ_REPEAT_EN
    cyc1(1'b1, 8'h5A, pk(4'hF, 0, 0, 1, 0),    "d1_reload");
`else
    cyc1(1'b1, 8'h5A, IDLE_OUT,                "d1_reload");
`endif
    cyc1(1'b0, 8'h00, pk(4'h5, 0, 0, 1, 0),    "d1_high2");
    cyc1(1'b0, 8'h00, pk(4'hA, 0, 1, 1, 0),    "d1_low2");
    cyc1(1'b1, 8'h3B, pk(4'hA, 1, 0, 1, 0),    "d1_gap_load_nodone");
    cyc1(1'b0, 8'h00, pk(4'h3, 0, 0, 1, 0),    "d1_high_after_gap_load");
    @(negedge clk);
    ld1 = 1'b0;

    // Dwell of two with 0x12: loops in repeat builds, finishes once otherwise.
    @(negedge clk);
    ld2  = 1'b1;
    dat2 = 8'h12;
    #1;
    chk("d2_load", out2, IDLE_OUT);
    for (int k = 1; k <= 18; k++) begin
      logic [7:0] e;
      int ph;
      @(negedge clk);
      ld2 = 1'b0;
      #1;
      ph = ((k - 1) / 2) % 3;
`ifndef HEXSEQ_REPEAT_EN
      if (k > 6) ph = 3;
`endif
      case (ph)
        0:       e = pk(4'h1, 0, 0, 1, 0);
        1:       e = pk(4'h2, 0, 1, 1, 0);
        2:       e = pk(4'h2, 1, 0, 1, ((k - 1) % 2) == 1);
        default: e = IDLE_OUT;
      endcase
      chk($sformatf("d2[%0d]", k), out2, e);
    end

    // Asynchronous reset in the middle of LOW, between clock edges.
    @(negedge clk);
    ld4  = 1'b1;
    dat4 = 8'h96;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      ld4 = 1'b0;
    end
    #1;
    chk("pre_reset_low", out4, pk(4'h6, 0, 1, 1, 0));
    reset = 1'b1;
    #1;
    chk("async_reset_u4", out4, IDLE_OUT);
    chk("async_reset_u2", out2, IDLE_OUT);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_reset_idle", out4, IDLE_OUT);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
